branch_resolver: RTL

- Sits beside `program_counter`, on the other side of its redirect interface.
- Each cycle it decodes the instruction fetched at the current `pc`. When it sees a branch or jump, it waits for the ALU condition flags if the branch is conditional.
- It then drives `pc_control`/`jump_offset` for exactly one cycle. That lands the free-running PC on the architecturally correct next address, because the PC has no stall input.
- It asserts `flush` over every wrong-path instruction fetched while the decision is pending.

---
 rtl/branch_pkg.sv | 30 +++
 rtl/branch_resolver.sv | 114 +++++++++++
 2 files changed

// File: rtl/branch_pkg.sv
// Opcode constants, FSM state type and offset helpers shared by the branch resolver.
package branch_pkg;

  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_BEQZ = 3'b110;
  localparam logic [2:0] OP_BNEG = 3'b111;

  localparam logic [7:0] PC_REDIRECT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  function automatic logic [7:0] sext5to8(input logic [4:0] v);
    return {{3{v[4]}}, v};
  endfunction

  function automatic logic is_branch(input logic [2:0] op);
    return (op == OP_JMP) || (op == OP_BEQZ) || (op == OP_BNEG);
  endfunction

  function automatic logic cond_taken(input logic [2:0] op, input logic zero, input logic neg);
    if (op == OP_BEQZ) return zero;
    if (op == OP_BNEG) return neg;
    return 1'b1;
  endfunction

endpackage

// File: rtl/branch_resolver.sv
// Decodes branches at the fetch PC, waits up to MAX_WAIT cycles for ALU flags, then issues a
// one-cycle PC redirect (1 cycle after decision); flush covers WAIT/RESOLVE since the PC cannot stall.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pc,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  input  logic       zero_flag,
  input  logic       neg_flag,
  input  logic       flag_valid,
  output logic [7:0] pc_control,
  output logic [7:0] jump_offset,
  output logic       flush,
  output logic       err
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic [7:0] cap_pc, cap_pc_nxt;
  logic [7:0] cap_off, cap_off_nxt;
  logic [2:0] cap_op, cap_op_nxt;
  logic [7:0] jump_reg, jump_nxt;
  logic       err_reg;
  logic       timeout_fire;
  logic [2:0] op;

  assign op = instr[7:5];

  // The PC adds pc+1 back on top of this, so it lands exactly on P+1(+off).
  function automatic logic [7:0] redirect_off(input logic [7:0] p, input logic [7:0] off,
                                              input logic [7:0] cur_pc, input logic taken);
    return p + (taken ? off : 8'h00) - (cur_pc + 8'h01);
  endfunction

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    cap_pc_nxt   = cap_pc;
    cap_off_nxt  = cap_off;
    cap_op_nxt   = cap_op;
    jump_nxt     = jump_reg;
    timeout_fire = 1'b0;

    case (state)
      IDLE: begin
        if (instr_valid && is_branch(op)) begin
          cap_pc_nxt  = pc;
          cap_op_nxt  = op;
          cap_off_nxt = sext5to8(instr[4:0]);
          if ((op == OP_JMP) || flag_valid) begin
            state_nxt = RESOLVE;
            jump_nxt  = redirect_off(pc, sext5to8(instr[4:0]), pc,
                                     cond_taken(op, zero_flag, neg_flag));
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = 8'h00;
          end
        end
      end

      WAIT: begin
        // A flag arriving on the timeout cycle still wins.
        if (flag_valid) begin
          state_nxt = RESOLVE;
          jump_nxt  = redirect_off(cap_pc, cap_off, pc,
                                   cond_taken(cap_op, zero_flag, neg_flag));
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt    = RESOLVE;
          timeout_fire = 1'b1;
          jump_nxt     = redirect_off(cap_pc, cap_off, pc, 1'b0);
        end else begin
          wait_cnt_nxt = wait_cnt + 8'h01;
        end
      end

      RESOLVE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 8'h00;
      cap_pc   <= 8'h00;
      cap_off  <= 8'h00;
      cap_op   <= 3'b000;
      jump_reg <= 8'h00;
      err_reg  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      cap_pc   <= cap_pc_nxt;
      cap_off  <= cap_off_nxt;
      cap_op   <= cap_op_nxt;
      jump_reg <= jump_nxt;
      err_reg  <= err_reg | timeout_fire;
    end
  end

  assign pc_control  = (state == RESOLVE) ? PC_REDIRECT : 8'h00;
  assign jump_offset = (state == RESOLVE) ? jump_reg : 8'h00;
  assign flush       = (state != IDLE);
  assign err         = err_reg;

endmodule
